grid_result_reader: RTL
=======================

# grid_result_reader

Row-sweep readout engine for the compute grid. On a start pulse it walks every grid row, waits the grid's fixed read latency, captures that row's per-cell result words into a local buffer, and streams them out one word per valid/ready handshake. It sits between the grid's row-select result mux and the downstream result sink. It also produces a running XOR checksum of everything it has emitted.

## Interface
- ROWS, 256, number of grid rows swept
- COLS, 64, result words per row
- WIDTH, 32, result word width
- RD_LAT, 2, cycles from an `o_row_sel` change until `i_row_data` is valid (≥1)
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset; one clock; reset is asynchronous and active-high
- i_start  in  1  single-cycle sweep request
- o_busy  out  1  sweep in progress (state ≠ IDLE)
- o_row_sel  out  $clog2(ROWS)  row index driven to the grid result mux
- i_row_data  in  COLS×WIDTH  packed [COLS-1:0][WIDTH-1:0]; word c = cell (o_row_sel, c)
- o_valid  out  1  o_data valid
- i_ready  in  1  sink accepts o_data
- o_data  out  WIDTH  current result word
- o_last  out  1  qualifies the final word of the sweep (row ROWS-1, col COLS-1)
- o_done  out  1  one-cycle pulse after the final handshake
- o_checksum  out  WIDTH  XOR of all words accepted since the last start

## Operation
- States: IDLE, SELECT, CAPTURE, DRAIN, DONE.
- IDLE: when i_start=1, clear the checksum, set row=0 and go to SELECT. i_start is ignored in every other state.
- SELECT: o_row_sel=row. Wait counter runs RD_LAT cycles, then goes to CAPTURE.
- CAPTURE: one cycle. Latch i_row_data into the COLS×WIDTH buffer, set col=0, go to DRAIN.
- DRAIN:
  - o_valid=1 and o_data=buf[col].
  - On a handshake (o_valid & i_ready): checksum ^= o_data, then col++.
  - Handshake at col=COLS-1 with row<ROWS-1: row++ and go to SELECT.
  - Handshake at col=COLS-1 with row=ROWS-1: go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- o_last = DRAIN & row==ROWS-1 & col==COLS-1.
- Once o_valid is asserted it stays high, and o_data/o_last stay stable, until the handshake completes. o_valid never depends combinationally on i_ready.
- Counters:
  - row and col are sized $clog2 and never wrap past ROWS-1/COLS-1.
  - The wait counter is sized $clog2(RD_LAT+1).
- o_checksum is held after DONE until the next start.
- o_row_sel holds its value through CAPTURE and DRAIN, and after DONE.

## Timing
- Reset values: state=IDLE, o_busy=0, o_row_sel=0, o_valid=0, o_data=0, o_last=0, o_done=0, o_checksum=0. Buffer contents are don't-care.
- Reset asserted mid-sweep takes effect immediately (asynchronous). Any partial row is discarded and the next start restarts from row 0.
- Start sampled at edge 0:
  - SELECT during cycles 1..RD_LAT.
  - CAPTURE at cycle RD_LAT+1.
  - First o_valid at cycle RD_LAT+2.
- Per row with i_ready held high: RD_LAT+1+COLS cycles.
- o_done is high the cycle after the last handshake. o_busy drops the cycle after that.
- All outputs are registered, except o_last and o_valid, which are decoded from registered state.

## Structure
- Shared package `grid_pkg`:
  - ROWS, COLS, WIDTH defaults.
  - Row-word typedef (logic [COLS-1:0][WIDTH-1:0]).
  - State enum.
  - Shared with the grid top.
- Natural sub-module: `grid_row_serializer`.
  - Contains the row buffer, col counter, valid/ready output stage and last-word flag.
  - Has a load strobe and a done-row strobe.
- The parent keeps the FSM, row counter, wait counter and checksum.

## Test plan
All scenarios use ROWS=3, COLS=3, RD_LAT=2. The grid model drives word (r,c) = (r<<4)|c, valid RD_LAT cycles after o_row_sel changes.
- Reset: assert i_reset asynchronously mid-cycle → all outputs 0 immediately, o_busy=0.
- Full sweep, i_ready=1:
  - Words 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
  - o_last only on 0x22.
  - First o_valid 4 cycles after start.
  - o_done one cycle after the 0x22 handshake.
  - o_checksum=0x33.
- Backpressure: i_ready=0 for 3 cycles while 0x11 is presented → o_valid, o_data=0x11 and o_last=0 held stable. Sequence and checksum are unchanged versus the previous scenario.
- Start while busy: pulse i_start during row-1 DRAIN → no restart. Sweep still ends on 0x22 with checksum 0x33 and a single o_done.
- Reset mid-sweep then restart: reset during row 1, then start → stream begins at 0x00, checksum cleared, final checksum 0x33.
- Back-to-back: start again in the cycle after o_done → second full identical sequence, checksum 0x33.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared grid definitions: default geometry, row-word type and readout states.
// Used by the result reader and by the grid top.
package grid_pkg;

   localparam int GRID_ROWS   = 256;
   localparam int GRID_COLS   = 64;
   localparam int GRID_WIDTH  = 32;
   localparam int GRID_RD_LAT = 2;

   typedef logic [GRID_COLS-1:0][GRID_WIDTH-1:0] row_word_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/grid_row_serializer.sv
// Row buffer plus valid/ready output stage; streams one captured grid row
// word by word and flags the handshake that retires the row.
module grid_row_serializer
   import grid_pkg::*;
#(
   parameter int COLS  = GRID_COLS,
   parameter int WIDTH = GRID_WIDTH
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_load,
   input  logic [COLS-1:0][WIDTH-1:0]  i_row_data,
   input  logic                        i_last_row,
   input  logic                        i_ready,
   output logic                        o_valid,
   output logic [WIDTH-1:0]            o_data,
   output logic                        o_last,
   output logic                        o_hs,
   output logic                        o_row_done
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   logic [COLS-1:0][WIDTH-1:0] r_buf;
   logic [CW-1:0]              r_col;
   logic                       r_active;
   logic [WIDTH-1:0]           r_data;
   logic                       w_hs;
   logic                       w_col_end;
   logic [CW-1:0]              w_next_col;

   assign w_hs       = r_active & i_ready;
   assign w_col_end  = (r_col == COL_MAX);
   assign w_next_col = r_col + CW'(1);

   assign o_valid    = r_active;
   assign o_data     = r_data;
   assign o_last     = r_active & i_last_row & w_col_end;
   assign o_hs       = w_hs;
   assign o_row_done = w_hs & w_col_end;

   // Buffer contents are don't-care out of reset, so it is left unreset.
   always_ff @(posedge i_clk) begin
      if (i_load) begin
         r_buf <= i_row_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_col    <= '0;
         r_active <= 1'b0;
         r_data   <= '0;
      end else if (i_load) begin
         r_col    <= '0;
         r_active <= 1'b1;
         r_data   <= i_row_data[0];
      end else if (w_hs) begin
         if (w_col_end) begin
            r_active <= 1'b0;
         end else begin
            r_col  <= w_next_col;
            r_data <= r_buf[w_next_col];
         end
      end
   end

endmodule

// File: rtl/grid_result_reader.sv
// Row-sweep readout engine: selects each grid row, waits the read latency,
// captures the row and streams it out while accumulating an XOR checksum.
module grid_result_reader
   import grid_pkg::*;
#(
   parameter int ROWS   = GRID_ROWS,
   parameter int COLS   = GRID_COLS,
   parameter int WIDTH  = GRID_WIDTH,
   parameter int RD_LAT = GRID_RD_LAT
) (
   input  logic                                       i_clk,
   input  logic                                       i_reset,
   input  logic                                       i_start,
   output logic                                       o_busy,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] o_row_sel,
   input  logic [COLS-1:0][WIDTH-1:0]                 i_row_data,
   output logic                                       o_valid,
   input  logic                                       i_ready,
   output logic [WIDTH-1:0]                           o_data,
   output logic                                       o_last,
   output logic                                       o_done,
   output logic [WIDTH-1:0]                           o_checksum
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int WW = $clog2(RD_LAT + 1);
   localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(RD_LAT - 1);

   state_t           r_state;
   logic [RW-1:0]    r_row;
   logic [WW-1:0]    r_wait;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_csum;
   logic             w_load;
   logic             w_last_row;
   logic             w_hs;
   logic             w_row_done;
   logic [WIDTH-1:0] w_data;

   assign w_load     = (r_state == S_CAPTURE);
   assign w_last_row = (r_row == ROW_MAX);

   assign o_busy     = r_busy;
   assign o_row_sel  = r_row;
   assign o_data     = w_data;
   assign o_done     = r_done;
   assign o_checksum = r_csum;

   grid_row_serializer #(
      .COLS  (COLS),
      .WIDTH (WIDTH)
   ) u_ser (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_row_data (i_row_data),
      .i_last_row (w_last_row),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_data     (w_data),
      .o_last     (o_last),
      .o_hs       (w_hs),
      .o_row_done (w_row_done)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_wait  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_csum  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_csum  <= '0;
                  r_row   <= '0;
                  r_wait  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (r_wait == WAIT_MAX) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_wait <= r_wait + WW'(1);
               end
            end
            S_CAPTURE: begin
               r_wait  <= '0;
               r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_hs) begin
                  r_csum <= r_csum ^ w_data;
               end
               if (w_row_done) begin
                  if (w_last_row) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_row   <= r_row + RW'(1);
                     r_state <= S_SELECT;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
